// File: rtl/marker_locator.sv
// Locates the first qualifying red/green/blue marker run per frame and reports one coordinate set per frame.
// Optional MARKER_STATS_EN adds drop_cnt, a saturating count of sof beats refused while a result is pending.
module marker_locator #(
  parameter int HI_TH   = 200,
  parameter int LO_TH   = 60,
  parameter int MIN_RUN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic        sof,
  input  logic        eof,
  input  logic [7:0]  raw_VGA_R,
  input  logic [7:0]  raw_VGA_G,
  input  logic [7:0]  raw_VGA_B,
  input  logic [12:0] row,
  input  logic [12:0] col,
  output logic [12:0] red_row,
  output logic [12:0] red_col,
  output logic [12:0] grn_row,
  output logic [12:0] grn_col,
  output logic [12:0] blu_row,
  output logic [12:0] blu_col,
  output logic [2:0]  found,
  output logic        res_valid,
`ifdef MARKER_STATS_EN
  output logic [15:0] drop_cnt,
`endif
  input  logic        res_ack
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  localparam logic [3:0]  RUN_MAX = 4'(MIN_RUN);
  localparam logic [12:0] RUN_OFS = 13'(MIN_RUN - 1);
  localparam logic [7:0]  HI      = 8'(HI_TH);
  localparam logic [7:0]  LO      = 8'(LO_TH);
  localparam logic [12:0] NONE    = 13'h1FFF;

  state_t state_q, state_d;
  logic [2:0][3:0]  cnt_q, cnt_d;
  logic [2:0][12:0] wrk_row_q, wrk_row_d, wrk_col_q, wrk_col_d;
  logic [2:0]       wrk_fnd_q, wrk_fnd_d;
  logic [2:0][12:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic [2:0]       out_fnd_q, out_fnd_d;
  logic             res_valid_q, res_valid_d;
  logic [12:0]      prev_row_q, prev_row_d, prev_col_q, prev_col_d;
  logic [2:0][7:0]  chan;
  logic [2:0]       match;
  logic             adj, start, cls;

  always_comb begin
    chan  = {raw_VGA_B, raw_VGA_G, raw_VGA_R};
    match = '0;
    for (int c = 0; c < 3; c++) begin
      match[c] = (chan[c] >= HI) && (chan[(c + 1) % 3] <= LO) && (chan[(c + 2) % 3] <= LO);
    end
    adj   = (row == prev_row_q) && (col == prev_col_q + 13'd1);
    // sof only opens a frame outside REPORT; in SCAN it also wins over eof
    start = pix_valid && sof && (state_q != REPORT);
    cls   = pix_valid && (start || (state_q == SCAN));

    cnt_d       = cnt_q;
    prev_row_d  = prev_row_q;
    prev_col_d  = prev_col_q;
    wrk_row_d   = wrk_row_q;
    wrk_col_d   = wrk_col_q;
    wrk_fnd_d   = wrk_fnd_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_fnd_d   = out_fnd_q;
    res_valid_d = res_valid_q;
    state_d     = state_q;

    if (start) begin
      wrk_row_d = {3{NONE}};
      wrk_col_d = {3{NONE}};
      wrk_fnd_d = '0;
    end

    if (cls) begin
      prev_row_d = row;
      prev_col_d = col;
      for (int c = 0; c < 3; c++) begin
        if (!match[c])                cnt_d[c] = 4'd0;
        else if (!adj)                cnt_d[c] = 4'd1;
        else if (cnt_q[c] >= RUN_MAX) cnt_d[c] = RUN_MAX;
        else                          cnt_d[c] = cnt_q[c] + 4'd1;
        if ((cnt_d[c] == RUN_MAX) && !wrk_fnd_d[c]) begin
          wrk_row_d[c] = row;
          wrk_col_d[c] = col - RUN_OFS;
          wrk_fnd_d[c] = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: begin
        if (!start && pix_valid && eof) begin
          out_row_d   = wrk_row_d;
          out_col_d   = wrk_col_d;
          out_fnd_d   = wrk_fnd_d;
          res_valid_d = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_row_q  <= '0;
      prev_col_q  <= '0;
      wrk_row_q   <= {3{NONE}};
      wrk_col_q   <= {3{NONE}};
      wrk_fnd_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_fnd_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_row_q  <= prev_row_d;
      prev_col_q  <= prev_col_d;
      wrk_row_q   <= wrk_row_d;
      wrk_col_q   <= wrk_col_d;
      wrk_fnd_q   <= wrk_fnd_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_fnd_q   <= out_fnd_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef MARKER_STATS_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if ((state_q == REPORT) && pix_valid && sof && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

  assign red_row   = out_row_q[0];
  assign red_col   = out_col_q[0];
  assign grn_row   = out_row_q[1];
  assign grn_col   = out_col_q[1];
  assign blu_row   = out_row_q[2];
  assign blu_col   = out_col_q[2];
  assign found     = out_fnd_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_marker_locator.sv
// Directed bench for marker_locator: sparse 640x480 frames carrying only the beats that matter.
// Builds with or without MARKER_STATS_EN.
module tb_marker_locator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0, sof = 1'b0, eof = 1'b0, res_ack = 1'b0;
  logic [7:0]  raw_VGA_R = '0, raw_VGA_G = '0, raw_VGA_B = '0;
  logic [12:0] row = '0, col = '0;
  logic [12:0] red_row, red_col, grn_row, grn_col, blu_row, blu_col;
  logic [2:0]  found;
  logic        res_valid;
`ifdef MARKER_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  localparam logic [12:0] NONE = 13'h1FFF;

  marker_locator dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .sof(sof), .eof(eof),
    .raw_VGA_R(raw_VGA_R), .raw_VGA_G(raw_VGA_G), .raw_VGA_B(raw_VGA_B),
    .row(row), .col(col),
    .red_row(red_row), .red_col(red_col), .grn_row(grn_row), .grn_col(grn_col),
    .blu_row(blu_row), .blu_col(blu_col), .found(found), .res_valid(res_valid),
`ifdef MARKER_STATS_EN
    .drop_cnt(drop_cnt),
`endif
    .res_ack(res_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int r, input int c, input logic [7:0] rr, input logic [7:0] gg,
                      input logic [7:0] bb, input logic s, input logic e);
    pix_valid = 1'b1; row = 13'(r); col = 13'(c);
    raw_VGA_R = rr; raw_VGA_G = gg; raw_VGA_B = bb; sof = s; eof = e;
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    raw_VGA_R = '0; raw_VGA_G = '0; raw_VGA_B = '0;
  endtask

  task automatic run_px(input int r, input int c0, input int n,
                        input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    for (int i = 0; i < n; i++) beat(r, c0 + i, rr, gg, bb, 1'b0, 1'b0);
  endtask

  task automatic frame_begin();
    beat(0, 0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic frame_end();
    beat(479, 639, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack();
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [2:0] f,
                         input logic [12:0] rr, input logic [12:0] rc,
                         input logic [12:0] gr, input logic [12:0] gc,
                         input logic [12:0] br, input logic [12:0] bc);
    chk({tag, ".found"},   32'(found),   32'(f));
    chk({tag, ".red_row"}, 32'(red_row), 32'(rr));
    chk({tag, ".red_col"}, 32'(red_col), 32'(rc));
    chk({tag, ".grn_row"}, 32'(grn_row), 32'(gr));
    chk({tag, ".grn_col"}, 32'(grn_col), 32'(gc));
    chk({tag, ".blu_row"}, 32'(blu_row), 32'(br));
    chk({tag, ".blu_col"}, 32'(blu_col), 32'(bc));
  endtask

  initial begin
    #12;
    chk_res("reset", 3'b000, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0);
    chk("reset.res_valid", 32'(res_valid), 32'd0);
`ifdef MARKER_STATS_EN
    chk("reset.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // stray eof in IDLE is ignored
    beat(479, 639, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("idle_eof.res_valid", 32'(res_valid), 32'd0);

    // red row 2 cols 1..4
    frame_begin();
    run_px(2, 1, 4, 8'd255, 8'd0, 8'd0);
    beat(2, 5, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("t1.pre_eof.res_valid", 32'(res_valid), 32'd0);
    frame_end();
    chk("t1.res_valid", 32'(res_valid), 32'd1);
    chk_res("t1", 3'b001, 13'd2, 13'd1, NONE, NONE, NONE, NONE);
    ack();
    chk("t1.ack.res_valid", 32'(res_valid), 32'd0);

    // run of 2 only
    frame_begin();
    run_px(7, 10, 2, 8'd255, 8'd0, 8'd0);
    beat(7, 12, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    frame_end();
    chk("t2.res_valid", 32'(res_valid), 32'd1);
    chk_res("t2", 3'b000, NONE, NONE, NONE, NONE, NONE, NONE);
    ack();

    // row wrap breaks the run; green and blue at frame edges, borderline levels
    frame_begin();
    run_px(0, 613, 4, 8'd60, 8'd200, 8'd60);
    beat(0, 617, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    run_px(5, 638, 2, 8'd255, 8'd0, 8'd0);
    beat(6, 0, 8'd255, 8'd0, 8'd0, 1'b0, 1'b0);
    beat(6, 1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    run_px(474, 0, 5, 8'd0, 8'd0, 8'd255);
    frame_end();
    chk_res("t3", 3'b110, NONE, NONE, 13'd0, 13'd613, 13'd474, 13'd0);

    // two frames while result pending: dropped
    for (int k = 0; k < 2; k++) begin
      frame_begin();
      run_px(10 + k, 5, 3, 8'd255, 8'd0, 8'd0);
      run_px(20 + k, 7, 3, 8'd0, 8'd255, 8'd0);
      frame_end();
    end
    chk("t4.res_valid", 32'(res_valid), 32'd1);
    chk_res("t4.hold", 3'b110, NONE, NONE, 13'd0, 13'd613, 13'd474, 13'd0);
`ifdef MARKER_STATS_EN
    chk("t4.drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    ack();
    frame_begin();
    run_px(20, 30, 3, 8'd255, 8'd0, 8'd0);
    frame_end();
    chk_res("t4.new", 3'b001, 13'd20, 13'd30, NONE, NONE, NONE, NONE);

    // sof coinciding with ack: ack taken, frame still dropped
    res_ack = 1'b1;
    beat(0, 0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
    res_ack = 1'b0;
    chk("t4b.ack.res_valid", 32'(res_valid), 32'd0);
    run_px(40, 1, 3, 8'd0, 8'd0, 8'd255);
    frame_end();
    chk("t4b.dropped.res_valid", 32'(res_valid), 32'd0);
`ifdef MARKER_STATS_EN
    chk("t4b.drop_cnt", 32'(drop_cnt), 32'd3);
`endif

    // mid-frame restart
    frame_begin();
    run_px(1, 0, 4, 8'd255, 8'd0, 8'd0);
    frame_begin();
    run_px(300, 20, 3, 8'd0, 8'd0, 8'd255);
    frame_end();
    chk("t5.res_valid", 32'(res_valid), 32'd1);
    chk_res("t5", 3'b100, NONE, NONE, NONE, NONE, 13'd300, 13'd20);
    ack();

    // async reset during SCAN
    frame_begin();
    run_px(3, 3, 3, 8'd0, 8'd255, 8'd0);
    #2 rst = 1'b1;
    #1;
    chk_res("t6.rst", 3'b000, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0);
    chk("t6.rst.res_valid", 32'(res_valid), 32'd0);
`ifdef MARKER_STATS_EN
    chk("t6.rst.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    frame_end();
    idle(2);
    chk("t6.aborted.res_valid", 32'(res_valid), 32'd0);
    frame_begin();
    run_px(100, 50, 3, 8'd0, 8'd255, 8'd0);
    frame_end();
    chk("t6.res_valid", 32'(res_valid), 32'd1);
    chk_res("t6", 3'b010, NONE, NONE, 13'd100, 13'd50, NONE, NONE);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/marker_locator.md
Name: marker_locator

Overview:
- Receive-side counterpart of the corner-marker overlay on the VGA output path.
- Scans the camera pixel stream coming back from the D8M capture path. Locates the red, green and blue calibration markers. Reports one coordinate set per frame over a valid/ack handshake.
- Feeds the downstream alignment/calibration logic.

Parameters:
- HI_TH, 200, minimum 8-bit level for a marker's dominant channel.
- LO_TH, 60, maximum 8-bit level for a marker's two other channels.
- MIN_RUN, 3, number of consecutive matching pixels in one row needed to qualify (legal range 1..15).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- pix_valid  in  1  the current beat carries an active pixel.
- sof  in  1  start of frame; pulses with the first pixel beat of a frame.
- eof  in  1  end of frame; pulses with the last pixel beat of a frame.
- raw_VGA_R/G/B  in  8 each  pixel colour.
- row  in  13  pixel row.
- col  in  13  pixel column.
- red_row, red_col, grn_row, grn_col, blu_row, blu_col  out  13 each  marker run start coordinates.
- found  out  3  {blue, green, red} detected flags.
- res_valid  out  1  result set available.
- res_ack  in  1  consumer accepts the result set.

Behaviour:
- Reset: all outputs 0, run counters 0, state IDLE.
- Classification, evaluated only on beats with pix_valid=1:
  - red = R>=HI_TH && G<=LO_TH && B<=LO_TH.
  - green and blue follow the same rule with the dominant channel swapped.
- Run counters: one 4-bit counter per colour, saturating at MIN_RUN.
  - Increments on a matching pixel when row equals the previous beat's row and col equals the previous col+1. Otherwise it loads 1 on a match, or 0 on a non-match.
  - A non-valid beat does not break a run.
- Capture: when a colour's counter reaches MIN_RUN and that colour is not yet captured this frame, latch row and col-(MIN_RUN-1) into working registers and set the working found bit. This gives the first qualifying run in raster order. Later runs are ignored.
- State machine IDLE -> SCAN -> REPORT:
  - IDLE: wait for sof with pix_valid. On that beat, clear the working registers (coords 13'h1FFF, found 0), classify the beat, go to SCAN.
  - SCAN: classify every beat.
    - On eof with pix_valid: classify that beat, copy the working registers to the outputs, assert res_valid next cycle, go to REPORT.
    - A sof in SCAN restarts the frame (working registers cleared, sof beat classified). It takes priority over eof in the same cycle.
    - The aborted frame is never reported.
  - REPORT: outputs stable, res_valid=1.
    - res_ack=1 in a cycle with res_valid=1: res_valid drops the next cycle, state returns to IDLE.
    - A sof during REPORT is ignored; that frame is dropped.
    - If res_ack and sof coincide: ack is taken, state goes to IDLE, the frame is still dropped.
- Latency: eof beat to res_valid = 1 cycle.
- Colours not found report coordinates 13'h1FFF and found bit 0.
- eof or beats seen in IDLE without sof are ignored.
- rst asserted mid-operation: immediate return to the reset values; the in-flight frame is discarded.

Optional Feature:
- MARKER_STATS_EN defined:
  - Adds port drop_cnt out 16, reset 0.
  - Increments on every sof not accepted because the state is REPORT, including the sof+ack cycle.
  - Saturates at 16'hFFFF.
- MARKER_STATS_EN undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- 640x480 frame, red (255,0,0) at row 2 cols 1..4, rest black -> 1 cycle after eof: res_valid=1, red_row=2, red_col=1, found=3'b001, green/blue coords 13'h1FFF.
- Red at row 7 cols 10..11 only (run 2 < MIN_RUN) -> found=0, red_row=red_col=13'h1FFF.
- Red at row 5 cols 638..639 and row 6 col 0 -> no detection. Green (0,255,0) row 0 cols 613..616 plus blue (0,0,255) row 474 cols 0..4 -> grn=(0,613), blu=(474,0), found=3'b110.
- Hold res_ack=0, send 2 more frames with different markers -> outputs unchanged, drop_cnt=2 (macro on). Ack, then next frame -> new results reported.
- Red found at row 1, then sof mid-frame, new frame with blue at row 300 col 20 -> reported found=3'b100, blu=(300,20).
- Assert rst during SCAN -> all outputs 0 immediately, res_valid stays 0. After release, a full frame reports correctly.
